// File: rtl/step_controller.sv
// CPU stepping engine: debounced step button, manual/auto/burst/breakpoint run
// modes, held CPU reset and a saturating step counter, all in the clk domain.
module step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned PERIOD0         = 50_000_000,
  parameter int unsigned PERIOD1         = 25_000_000,
  parameter int unsigned PERIOD2         = 5_000_000,
  parameter int unsigned PERIOD3         = 50_000,
  parameter int unsigned BURST_W         = 8,
  parameter int unsigned PC_W            = 32,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_btn_n,
  input  logic               cpu_rst_req,
  input  logic [1:0]         run_mode,
  input  logic [1:0]         rate_sel,
  input  logic [BURST_W-1:0] burst_count,
  input  logic               bp_enable,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc,
  output logic               cpu_ce,
  output logic               cpu_reset,
  output logic               busy,
  output logic               halted_at_bp,
  output logic [COUNT_W-1:0] step_count
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TMR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_AUTO,
    S_BURST,
    S_RUN_BP,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    M_MANUAL = 2'b00,
    M_AUTO   = 2'b01,
    M_BURST  = 2'b10,
    M_BP     = 2'b11
  } mode_t;

  // Button synchronizer and debouncer
  logic            r_btn_s1;
  logic            r_btn_s2;
  logic            r_btn_db;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press;
  logic            w_db_accept;

  assign w_db_accept = (r_btn_s2 != r_btn_db) && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= 1'b1;
      r_btn_s2 <= 1'b1;
      r_btn_db <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_btn_s1 <= step_btn_n;
      r_btn_s2 <= r_btn_s1;
      r_press  <= w_db_accept && !r_btn_s2;
      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (w_db_accept) begin
        r_btn_db <= r_btn_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // Control state
  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_mode_q;
  logic [BURST_W-1:0] r_remaining;
  logic [BURST_W-1:0] w_rem_nxt;
  logic [TMR_W-1:0]   r_tmr;
  logic [TMR_W-1:0]   w_period;
  logic               w_tick;
  logic               w_tmr_clr;
  logic               w_mode_chg;
  logic               w_bp_hit;
  logic               w_ce;
  logic               r_cpu_ce;
  logic               r_cpu_reset;
  logic               r_busy;
  logic               r_halted;
  logic [COUNT_W-1:0] r_step_cnt;

  always_comb begin
    w_period = TMR_W'(PERIOD0);
    case (rate_sel)
      2'd0:    w_period = TMR_W'(PERIOD0);
      2'd1:    w_period = TMR_W'(PERIOD1);
      2'd2:    w_period = TMR_W'(PERIOD2);
      default: w_period = TMR_W'(PERIOD3);
    endcase
  end

  // >= rather than == so a shorter newly selected period fires at once
  assign w_tick     = (r_tmr >= (w_period - 1'b1));
  assign w_mode_chg = (run_mode != r_mode_q);
  assign w_bp_hit   = bp_enable && (pc == bp_addr);
  assign w_tmr_clr  = (w_state_nxt != r_state) || w_mode_chg || cpu_rst_req;

  always_comb begin
    w_state_nxt = r_state;
    w_ce        = 1'b0;
    w_rem_nxt   = r_remaining;
    if (cpu_rst_req || w_mode_chg) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          case (run_mode)
            M_MANUAL: w_ce = r_press;
            M_AUTO:   w_state_nxt = S_RUN_AUTO;
            M_BURST: begin
              // The first burst step issues together with the load
              if (r_press && (burst_count != '0)) begin
                w_ce        = 1'b1;
                w_rem_nxt   = burst_count - 1'b1;
                w_state_nxt = S_BURST;
              end
            end
            default: begin
              if (r_press) begin
                if (w_bp_hit) begin
                  w_state_nxt = S_HALT;
                end else begin
                  w_ce        = 1'b1;
                  w_state_nxt = S_RUN_BP;
                end
              end
            end
          endcase
        end
        S_RUN_AUTO: w_ce = w_tick;
        S_BURST: begin
          if (r_press) begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = '0;
          end else if (r_remaining == '0) begin
            w_state_nxt = S_IDLE;
          end else if (w_tick) begin
            w_ce      = 1'b1;
            w_rem_nxt = r_remaining - 1'b1;
          end
        end
        S_RUN_BP: begin
          if (w_tick) begin
            if (w_bp_hit) begin
              w_state_nxt = S_HALT;
            end else begin
              w_ce = 1'b1;
            end
          end
        end
        S_HALT: begin
          if (r_press) begin
            w_ce        = 1'b1;
            w_state_nxt = S_RUN_BP;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode_q    <= 2'b00;
      r_remaining <= '0;
      r_tmr       <= '0;
      r_cpu_ce    <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_step_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_q    <= run_mode;
      r_remaining <= w_rem_nxt;
      r_cpu_ce    <= w_ce;
      r_busy      <= (w_state_nxt == S_RUN_AUTO) || (w_state_nxt == S_BURST) ||
                     (w_state_nxt == S_RUN_BP);
      r_halted    <= (w_state_nxt == S_HALT);
      if (w_tmr_clr || w_tick) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
      if (cpu_rst_req) begin
        r_cpu_reset <= 1'b1;
      end else if (r_cpu_ce) begin
        r_cpu_reset <= 1'b0;
      end
      if (cpu_rst_req) begin
        r_step_cnt <= '0;
      end else if (w_ce && (r_step_cnt != '1)) begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end
    end
  end

  assign cpu_ce       = r_cpu_ce;
  assign cpu_reset    = r_cpu_reset;
  assign busy         = r_busy;
  assign halted_at_bp = r_halted;
  assign step_count   = r_step_cnt;

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Single-clock CPU stepping engine for the board-level debug top. Replaces the gated/extended-pulse CPU clock scheme with a one-cycle clock-enable (cpu_ce) in the clk domain.
- Adds four run modes: manual, auto, burst-N and run-to-breakpoint. Adds a selectable auto rate, a debounced step button, held CPU reset, and a saturating step counter.
- Sits between the board buttons/switches and the monocycle CPU. The CPU advances only on cycles where cpu_ce is high.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of stable synchronized cycles required before the button level is accepted.
- PERIOD0, 50_000_000, auto/burst step period in clk cycles for rate_sel=0.
- PERIOD1, 25_000_000, step period for rate_sel=1.
- PERIOD2, 5_000_000, step period for rate_sel=2.
- PERIOD3, 50_000, step period for rate_sel=3.
- BURST_W, 8, width of burst_count.
- PC_W, 32, width of pc and bp_addr.
- COUNT_W, 16, width of step_count.

Ports:
- clk  input  1  system clock (50 MHz on board)
- rst_n  input  1  asynchronous, active-low reset
- step_btn_n  input  1  raw step button, active low, asynchronous to clk
- cpu_rst_req  input  1  one-cycle pulse requesting a CPU reset (already debounced/edge-detected)
- run_mode  input  2  00 manual, 01 auto, 10 burst, 11 run-to-breakpoint
- rate_sel  input  2  selects PERIOD0..PERIOD3
- burst_count  input  BURST_W  number of steps per burst
- bp_enable  input  1  breakpoint compare enable
- bp_addr  input  PC_W  breakpoint address
- pc  input  PC_W  current CPU program counter
- cpu_ce  output  1  one-cycle step enable to the CPU
- cpu_reset  output  1  CPU reset, sampled by the CPU on a cpu_ce cycle
- busy  output  1  high in RUN_AUTO, BURST or RUN_BP
- halted_at_bp  output  1  high in HALT
- step_count  output  COUNT_W  number of cpu_ce pulses since the last reset; saturates at all-ones

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: cpu_ce=0, cpu_reset=1, busy=0, halted_at_bp=0, step_count=0.
  - State IDLE; all counters 0; debounced button level = released.
- Button path:
  - step_btn_n passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized level differs from the debounced level, clears otherwise, and accepts the new level at DEBOUNCE_CYCLES.
  - press = one-cycle pulse on the released→pressed transition. Pressed→released transitions produce no pulse.
  - Latency from raw falling edge to press: DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+4 cycles.
  - Bounces shorter than DEBOUNCE_CYCLES produce no press.
- Period timer:
  - Counts 0..P-1, where P = PERIOD[rate_sel] sampled each cycle. tick is asserted at P-1, then the timer wraps to 0.
  - The timer clears on every state entry.
  - If rate_sel changes so that the count is already ≥P-1, tick fires on the next cycle.
- States:
  - IDLE, manual: press → cpu_ce on the next cycle. Remain in IDLE.
  - IDLE, run_mode=01: enter RUN_AUTO.
  - IDLE, run_mode=10 with press: load remaining=burst_count. If burst_count=0, no cpu_ce and stay in IDLE; otherwise enter BURST.
  - IDLE, run_mode=11 with press: enter RUN_BP.
  - RUN_AUTO: cpu_ce on every tick; the first cpu_ce occurs P cycles after entry. press is ignored.
  - BURST:
    - The first cpu_ce occurs on the cycle after entry; each later cpu_ce occurs on tick.
    - remaining decrements on each cpu_ce; leave for IDLE on the cycle after the cpu_ce that takes remaining to 0.
    - A press during BURST aborts to IDLE with no further cpu_ce.
  - RUN_BP:
    - cpu_ce timing is the same as BURST (first on the next cycle, then on each tick).
    - When a cpu_ce would fire, first check the breakpoint. If bp_enable=1 and pc==bp_addr, suppress that cpu_ce and enter HALT.
  - HALT:
    - halted_at_bp=1, no cpu_ce.
    - press → one cpu_ce on the next cycle that skips the breakpoint compare, then return to RUN_BP with the timer cleared.
- Mode change:
  - Any change of run_mode (registered compare) forces IDLE, clears remaining and the timer, and clears halted_at_bp.
  - Any press in that same cycle is discarded.
- CPU reset:
  - cpu_rst_req sets cpu_reset=1, forces IDLE and clears step_count.
  - cpu_reset stays 1 until a cpu_ce has been issued, then clears on the cycle after that cpu_ce. That first step performs the CPU reset.
  - cpu_rst_req together with press in the same cycle: reset wins and the press is discarded.
  - cpu_rst_req together with a would-be cpu_ce: the cpu_ce is suppressed.
- Output rules:
  - cpu_ce is never high on two consecutive cycles, except when P=1.
  - busy is registered and reflects the current state.
  - step_count increments on each cpu_ce and holds at 2^COUNT_W−1.

Test Plan (DEBOUNCE_CYCLES=4, PERIOD0..3=10,6,3,1, COUNT_W=4):
- Manual debounce: run_mode=00; raw glitch low for 2 cycles → no cpu_ce. Clean press held 20 cycles → exactly one cpu_ce 6–8 cycles after the edge. Release → no cpu_ce.
- Auto rate: run_mode=01, rate_sel=0 → cpu_ce at 10, 20, 30 cycles after entry. Switch rate_sel=2 → cpu_ce every 3 cycles. step_count saturates at 15.
- Burst: run_mode=10, burst_count=3, rate_sel=1, press → cpu_ce at +1, +7, +13, then IDLE with busy=0. burst_count=0 → no cpu_ce. Second press mid-burst → abort after the current cpu_ce count.
- Breakpoint: run_mode=11, bp_enable=1, bp_addr=0x0C; pc tracked as 4×cpu_ce count → cpu_ce issued at pc=0, 4, 8, then HALT with halted_at_bp=1. press → one cpu_ce, pc=0x10, continue in RUN_BP.
- Reset precedence: cpu_rst_req and press in the same cycle → no cpu_ce, cpu_reset=1, step_count=0. Next press → cpu_ce with cpu_reset=1, cpu_reset=0 on the following cycle.
- Async reset mid-burst: rst_n low for 1 cycle → all outputs at reset values immediately; no cpu_ce after rst_n rises until a new press.
